// File: rtl/hazard_ctrl_unit.sv
// Hazard control for the 8-bit pipelined core: load-use stall, branch flush, multi-cycle EX sequencing.
// Optional feature: define HAZARD_PERF_CNT_EN to build saturating stall/flush performance counters.
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W     = 2,
  parameter int MC_CYCLES      = 4,
  parameter int BRANCH_PENALTY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_mc_op,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  pc_write_en,
  output logic                  id_ex_bubble,
  output logic                  busy,
  output logic [15:0]           stall_cnt,
  output logic [15:0]           flush_cnt
);

  localparam int CNT_W = $clog2(16);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    MC_BUSY = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lu;
  logic             stall_c, flush_c, pcw_c, bubble_c, busy_c;

  assign lu = ex_mem_read &
              ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_c   = 1'b0;
    flush_c   = 1'b0;
    pcw_c     = 1'b0;
    bubble_c  = 1'b0;
    busy_c    = 1'b0;
    case (state)
      IDLE: begin
        pcw_c = 1'b1;
        if (ex_branch_taken) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          if (BRANCH_PENALTY > 1) begin
            state_nxt = FLUSH;
            cnt_nxt   = CNT_W'(BRANCH_PENALTY - 1);
          end
        end else if (lu) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          pcw_c    = 1'b0;
        end else if (id_mc_op) begin
          state_nxt = MC_BUSY;
          cnt_nxt   = CNT_W'(MC_CYCLES - 1);
        end
      end
      FLUSH: begin
        flush_c  = 1'b1;
        bubble_c = 1'b1;
        pcw_c    = 1'b1;
        busy_c   = 1'b1;
        if (cnt <= CNT_W'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      MC_BUSY: begin
        // EX is occupied by the multi-cycle op, so branch and load-use are not looked at.
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        busy_c   = 1'b1;
        if (cnt <= CNT_W'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs are combinational, so gate them with rst_n to keep them quiet while reset is held.
  assign if_id_stall  = rst_n & stall_c;
  assign if_id_flush  = rst_n & flush_c;
  assign pc_write_en  = rst_n & pcw_c;
  assign id_ex_bubble = rst_n & bubble_c;
  assign busy         = rst_n & busy_c;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (if_id_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 16'd1;
      if (if_id_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif

endmodule
